// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter / return-address-stack unit.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_OP_HOLD,
    PC_OP_INC,
    PC_OP_LOAD,
    PC_OP_REL,
    PC_OP_CALL,
    PC_OP_RET
  } pc_op_t;

  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Stall outranks every command; ret outranks call when both arrive together.
  function automatic pc_op_t pc_sel(input logic stall, input logic ret, input logic call,
                                    input logic load, input logic rel, input logic inc);
    if (stall)     return PC_OP_HOLD;
    else if (ret)  return PC_OP_RET;
    else if (call) return PC_OP_CALL;
    else if (load) return PC_OP_LOAD;
    else if (rel)  return PC_OP_REL;
    else if (inc)  return PC_OP_INC;
    else           return PC_OP_HOLD;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  output logic [PC_WIDTH-1:0] top_o,
  output logic                full_o,
  output logic                empty_o
);
  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                full_q, empty_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && cnt_q != '0) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  // Pointer wraps at RAS_DEPTH, so pushing while full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (!reset && push_i) mem_q[ptr_d] <= push_data_i;
  end

  assign top_o   = mem_q[ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with inc/load/relative branch, stall and call/return via RAS.
// Optional PC_TRACE_EN adds prev_pc and branch_taken outputs.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = 16,
  parameter int RAS_DEPTH    = 4,
  parameter int RESET_VECTOR = 0,
  parameter int INC_STEP     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                inc,
  input  logic                load_enable,
  input  logic [PC_WIDTH-1:0] data_in,
  input  logic                rel_enable,
  input  logic [PC_WIDTH-1:0] offset,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] data_out,
`ifdef PC_TRACE_EN
  output logic [PC_WIDTH-1:0] prev_pc,
  output logic                branch_taken,
`endif
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_overflow,
  output logic                ras_underflow
);
  localparam logic [PC_WIDTH-1:0] RST_VEC_C = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] STEP_C    = PC_WIDTH'(INC_STEP);

  pc_op_t              op;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                push, pop;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_full_w, ras_empty_w;

  assign op = pc_sel(stall, ret, call, load_enable, rel_enable, inc);

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (op)
      PC_OP_RET: begin
        if (!ras_empty_w) begin
          pc_d = ras_top;
          pop  = 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
      PC_OP_CALL: begin
        push = 1'b1;
        pc_d = data_in;
        if (ras_full_w) ovf_d = 1'b1;
      end
      PC_OP_LOAD: pc_d = data_in;
      PC_OP_REL:  pc_d = pc_q + offset;
      PC_OP_INC:  pc_d = pc_q + STEP_C;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RST_VEC_C;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_stack #(
    .PC_WIDTH (PC_WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(pc_q + STEP_C),
    .top_o      (ras_top),
    .full_o     (ras_full_w),
    .empty_o    (ras_empty_w)
  );

  assign data_out      = pc_q;
  assign ras_empty     = ras_empty_w;
  assign ras_full      = ras_full_w;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

`ifdef PC_TRACE_EN
  logic [PC_WIDTH-1:0] prev_q;
  logic                bt_q;
  logic                ret_ok, taken, upd;

  // An underflowing ret leaves the PC alone, so it neither pulses nor moves prev_pc.
  assign ret_ok = (op == PC_OP_RET) && !ras_empty_w;
  assign taken  = ret_ok || (op == PC_OP_CALL) || (op == PC_OP_LOAD) || (op == PC_OP_REL);
  assign upd    = taken || (op == PC_OP_INC);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      bt_q   <= 1'b0;
    end else begin
      bt_q <= taken;
      if (upd) prev_q <= pc_q;
    end
  end

  assign prev_pc      = prev_q;
  assign branch_taken = bt_q;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit; define PC_TRACE_EN to also cover the trace outputs.
module tb_pc_stack_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, inc = 1'b0, load_enable = 1'b0;
  logic        rel_enable = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] data_in = '0, offset = '0;
  logic [15:0] data_out;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;
`ifdef PC_TRACE_EN
  logic [15:0] prev_pc;
  logic        branch_taken;
`endif

  pc_stack_unit #(
    .PC_WIDTH(16), .RAS_DEPTH(4), .RESET_VECTOR(0), .INC_STEP(1)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .inc(inc),
    .load_enable(load_enable), .data_in(data_in),
    .rel_enable(rel_enable), .offset(offset),
    .call(call), .ret(ret), .data_out(data_out),
`ifdef PC_TRACE_EN
    .prev_pc(prev_pc), .branch_taken(branch_taken),
`endif
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: an unbounded list trimmed from the front when it exceeds depth 4.
  logic [15:0] m_pc = '0;
  logic [15:0] m_ras[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;

  // {pc, empty, full, overflow, underflow}
  logic [19:0] sb[$];
  logic [19:0] act_q[$];

  task automatic drive(input logic rst, input logic st, input logic i, input logic ld,
                       input logic [15:0] din, input logic rl, input logic [15:0] off,
                       input logic cl, input logic rt);
    reset = rst; stall = st; inc = i; load_enable = ld; data_in = din;
    rel_enable = rl; offset = off; call = cl; ret = rt;
    if (rst) begin
      m_pc = 16'h0000; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!st) begin
      if (rt) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else m_unf = 1'b1;
      end else if (cl) begin
        m_ras.push_back(m_pc + 16'd1);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = din;
      end else if (ld) m_pc = din;
      else if (rl) m_pc = m_pc + off;
      else if (i)  m_pc = m_pc + 16'd1;
    end
    sb.push_back({m_pc, m_ras.size() == 0, m_ras.size() == 4, m_ovf, m_unf});
    @(posedge clk);
    #1;
    act_q.push_back({data_out, ras_empty, ras_full, ras_overflow, ras_underflow});
    reset = 0; stall = 0; inc = 0; load_enable = 0; rel_enable = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset;
    logic [19:0] e, a;
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    n_total++;
    if (data_out !== 16'h0000 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0)
      $display("FAIL reset_state: got pc=%h e=%b f=%b o=%b u=%b want pc=0000 e=1 f=0 o=0 u=0",
               data_out, ras_empty, ras_full, ras_overflow, ras_underflow);
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL reset_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_inc;
    logic [19:0] e, a;
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
    n_total++;
    if (data_out !== 16'h0003) $display("FAIL inc3: got %h want 0003", data_out); else n_pass++;
    drive(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(1, 0, 1, 1, 16'h1234, 0, 16'h0, 1, 0);
    n_total++;
    if (data_out !== 16'h0000) $display("FAIL mid_reset: got %h want 0000", data_out); else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL inc_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_branch;
    logic [19:0] e, a;
    drive(0, 0, 0, 1, 16'h0100, 0, 16'h0, 0, 0);
    n_total++;
    if (data_out !== 16'h0100) $display("FAIL load: got %h want 0100", data_out); else n_pass++;
    drive(0, 0, 0, 0, 16'h0, 1, 16'hFFFE, 0, 0);
    n_total++;
    if (data_out !== 16'h00FE) $display("FAIL rel_neg: got %h want 00FE", data_out); else n_pass++;
    drive(0, 0, 0, 1, 16'hFFFF, 0, 16'h0, 0, 0);
    drive(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
    n_total++;
    if (data_out !== 16'h0000) $display("FAIL inc_wrap: got %h want 0000", data_out); else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL branch_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_call_ret;
    logic [19:0] e, a;
    drive(0, 0, 0, 1, 16'h0010, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 0, 16'h0200, 0, 16'h0, 1, 0);
    drive(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1);
    n_total++;
    if (data_out !== 16'h0011 || ras_empty !== 1'b1)
      $display("FAIL call_ret: got pc=%h e=%b want pc=0011 e=1", data_out, ras_empty);
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL call_ret_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_overflow;
    logic [19:0] e, a;
    logic [15:0] want[4];
    want[0] = 16'h0041; want[1] = 16'h0031; want[2] = 16'h0021; want[3] = 16'h0011;
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    for (int k = 1; k <= 5; k++) drive(0, 0, 0, 0, 16'(k * 16), 0, 16'h0, 1, 0);
    n_total++;
    if (ras_full !== 1'b1 || ras_overflow !== 1'b1)
      $display("FAIL ovf_flags: got f=%b o=%b want f=1 o=1", ras_full, ras_overflow);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1);
      n_total++;
      if (data_out !== want[k]) $display("FAIL ret_%0d: got %h want %h", k, data_out, want[k]);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 1);
    n_total++;
    if (data_out !== 16'h0011 || ras_underflow !== 1'b1)
      $display("FAIL underflow: got pc=%h u=%b want pc=0011 u=1", data_out, ras_underflow);
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL ovf_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_stall;
    logic [19:0] e, a;
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 1, 16'h0070, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 0, 16'h0300, 0, 16'h0, 1, 0);
    drive(0, 1, 1, 1, 16'h0555, 1, 16'h0004, 1, 1);
    n_total++;
    if (data_out !== 16'h0300 || ras_empty !== 1'b0 || ras_underflow !== 1'b0)
      $display("FAIL stall: got pc=%h e=%b u=%b want pc=0300 e=0 u=0", data_out, ras_empty, ras_underflow);
    else n_pass++;
    drive(0, 0, 0, 0, 16'h0999, 0, 16'h0, 1, 1);
    n_total++;
    if (data_out !== 16'h0071 || ras_empty !== 1'b1)
      $display("FAIL call_and_ret: got pc=%h e=%b want pc=0071 e=1", data_out, ras_empty);
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL stall_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [19:0] e, a;
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), $urandom_range(0, 5) == 0, 16'($urandom),
            $urandom_range(0, 4) == 0, 16'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = act_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL random_sb: got %h want %h", a, e); else n_pass++;
    end
  endtask

`ifdef PC_TRACE_EN
  task automatic test_trace;
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 1, 16'h0005, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 1, 16'h0040, 0, 16'h0, 0, 0);
    n_total++;
    if (prev_pc !== 16'h0005 || branch_taken !== 1'b1)
      $display("FAIL trace_load: got prev=%h bt=%b want prev=0005 bt=1", prev_pc, branch_taken);
    else n_pass++;
    drive(0, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
    n_total++;
    if (branch_taken !== 1'b0 || prev_pc !== 16'h0040)
      $display("FAIL trace_inc: got prev=%h bt=%b want prev=0040 bt=0", prev_pc, branch_taken);
    else n_pass++;
    sb.delete();
    act_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_inc();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_random();
`ifdef PC_TRACE_EN
    test_trace();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
